// File: rtl/pipelined_control_unit_if.sv
// ID-side instruction fields and EX-side control word
// exchanged with the pipelined control unit.
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) ();
  logic                  id_valid;
  logic [5:0]            id_opcode;
  logic [5:0]            id_funct;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  flush;

  logic                  stall;
  logic                  mul_busy;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_mem_to_reg;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_alu_src;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_jump_reg;
  logic                  ex_sign_extend_mem;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic [1:0]            ex_mem_size;
  logic [REG_ADDR_W-1:0] ex_dest;

  modport master (
    output id_valid,
    output id_opcode,
    output id_funct,
    output id_rs,
    output id_rt,
    output id_rd,
    output flush,
    input  stall,
    input  mul_busy,
    input  ex_valid,
    input  ex_reg_write,
    input  ex_mem_to_reg,
    input  ex_mem_read,
    input  ex_mem_write,
    input  ex_alu_src,
    input  ex_branch,
    input  ex_jump,
    input  ex_jump_reg,
    input  ex_sign_extend_mem,
    input  ex_alu_op,
    input  ex_mem_size,
    input  ex_dest
  );

  modport slave (
    input  id_valid,
    input  id_opcode,
    input  id_funct,
    input  id_rs,
    input  id_rt,
    input  id_rd,
    input  flush,
    output stall,
    output mul_busy,
    output ex_valid,
    output ex_reg_write,
    output ex_mem_to_reg,
    output ex_mem_read,
    output ex_mem_write,
    output ex_alu_src,
    output ex_branch,
    output ex_jump,
    output ex_jump_reg,
    output ex_sign_extend_mem,
    output ex_alu_op,
    output ex_mem_size,
    output ex_dest
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// MIPS ID-stage decode registered into ID/EX, with load-use
// stall, multi-cycle MUL occupancy and flush-to-bubble.
module pipelined_control_unit #(
  parameter int MUL_LATENCY = 4,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_OP_W    = 4,
  parameter int LINK_REG    = 31
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam int CNT_W =
    (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] FN_JR       = 6'h08;
  localparam logic [5:0] FN_MUL      = 6'h02;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_MUL = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = '1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
    logic                  jump_reg;
    logic                  sign_ext;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [1:0]            mem_size;
    logic [REG_ADDR_W-1:0] dest;
  } ctrl_t;

  typedef enum logic {
    S_RUN,
    S_MUL_WAIT
  } state_t;

  if (MUL_LATENCY < 1) begin : g_bad_lat
    $error("MUL_LATENCY must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  ctrl_t             r_ex;
  ctrl_t             w_ex_nxt;
  ctrl_t             w_dec;
  logic [5:0]        w_op;
  logic              w_use_rs;
  logic              w_use_rt;
  logic              w_is_mul;
  logic              w_hazard;
  logic              w_stall;

  assign w_op = bus.id_opcode;

  always_comb begin
    w_dec    = '0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_is_mul = 1'b0;
    if (bus.id_valid) begin
      unique case (1'b1)
        (w_op == OP_SPECIAL): begin
          w_dec.valid = 1'b1;
          w_dec.dest  = bus.id_rd;
          w_use_rs    = 1'b1;
          if (bus.id_funct == FN_JR) begin
            w_dec.jump_reg = 1'b1;
          end else begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = ALU_FN;
            w_use_rt        = 1'b1;
          end
        end
        (w_op == OP_SPECIAL2): begin
          // other SPECIAL2 functs are unsupported -> bubble
          if (bus.id_funct == FN_MUL) begin
            w_dec.valid     = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = ALU_MUL;
            w_dec.dest      = bus.id_rd;
            w_use_rs        = 1'b1;
            w_use_rt        = 1'b1;
            w_is_mul        = 1'b1;
          end
        end
        (w_op == OP_ADDI),
        (w_op == OP_SLTI),
        (w_op == OP_ANDI),
        (w_op == OP_ORI),
        (w_op == OP_XORI): begin
          w_dec.valid     = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.dest      = bus.id_rt;
          w_use_rs        = 1'b1;
          unique case (1'b1)
            (w_op == OP_SLTI): w_dec.alu_op = ALU_SLT;
            (w_op == OP_ANDI): w_dec.alu_op = ALU_AND;
            (w_op == OP_ORI):  w_dec.alu_op = ALU_OR;
            (w_op == OP_XORI): w_dec.alu_op = ALU_XOR;
            default:           w_dec.alu_op = ALU_ADD;
          endcase
        end
        (w_op == OP_LW),
        (w_op == OP_LH),
        (w_op == OP_LB): begin
          w_dec.valid      = 1'b1;
          w_dec.reg_write  = 1'b1;
          w_dec.mem_to_reg = 1'b1;
          w_dec.mem_read   = 1'b1;
          w_dec.alu_src    = 1'b1;
          w_dec.alu_op     = ALU_ADD;
          w_dec.sign_ext   = (w_op != OP_LW);
          w_dec.dest       = bus.id_rt;
          w_use_rs         = 1'b1;
          unique case (1'b1)
            (w_op == OP_LW): w_dec.mem_size = SZ_W;
            (w_op == OP_LH): w_dec.mem_size = SZ_H;
            default:         w_dec.mem_size = SZ_B;
          endcase
        end
        (w_op == OP_SW),
        (w_op == OP_SH),
        (w_op == OP_SB): begin
          w_dec.valid     = 1'b1;
          w_dec.mem_write = 1'b1;
          w_dec.alu_src   = 1'b1;
          w_dec.alu_op    = ALU_ADD;
          w_dec.dest      = bus.id_rt;
          w_use_rs        = 1'b1;
          w_use_rt        = 1'b1;
          unique case (1'b1)
            (w_op == OP_SW): w_dec.mem_size = SZ_W;
            (w_op == OP_SH): w_dec.mem_size = SZ_H;
            default:         w_dec.mem_size = SZ_B;
          endcase
        end
        (w_op == OP_BEQ),
        (w_op == OP_BNE): begin
          w_dec.valid  = 1'b1;
          w_dec.branch = 1'b1;
          w_dec.alu_op = ALU_SUB;
          w_dec.dest   = bus.id_rt;
          w_use_rs     = 1'b1;
          w_use_rt     = 1'b1;
        end
        (w_op == OP_BLEZ),
        (w_op == OP_BGTZ),
        (w_op == OP_REGIMM): begin
          w_dec.valid  = 1'b1;
          w_dec.branch = 1'b1;
          w_dec.alu_op = ALU_SUB;
          w_dec.dest   = bus.id_rt;
          w_use_rs     = 1'b1;
        end
        (w_op == OP_J): begin
          w_dec.valid = 1'b1;
          w_dec.jump  = 1'b1;
          w_dec.dest  = bus.id_rt;
        end
        (w_op == OP_JAL): begin
          w_dec.valid     = 1'b1;
          w_dec.jump      = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.dest      = REG_ADDR_W'(LINK_REG);
        end
        default: ;
      endcase
    end
  end

  // $0 is never a real producer, so a load into it cannot stall
  assign w_hazard = r_ex.valid & r_ex.mem_read &
                    (r_ex.dest != '0) &
                    ((w_use_rs & (bus.id_rs == r_ex.dest)) |
                     (w_use_rt & (bus.id_rt == r_ex.dest)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ex_nxt    = r_ex;
    w_stall     = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_ex_nxt    = '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          w_stall = w_hazard;
          if (w_hazard) begin
            w_ex_nxt = '0;
          end else begin
            w_ex_nxt = w_dec;
            if (w_is_mul && (MUL_LATENCY > 1)) begin
              w_state_nxt = S_MUL_WAIT;
              w_cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
            end
          end
        end
        S_MUL_WAIT: begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_ex    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ex    <= w_ex_nxt;
    end
  end

  assign bus.stall              = w_stall;
  assign bus.mul_busy           = (r_state == S_MUL_WAIT);
  assign bus.ex_valid           = r_ex.valid;
  assign bus.ex_reg_write       = r_ex.reg_write;
  assign bus.ex_mem_to_reg      = r_ex.mem_to_reg;
  assign bus.ex_mem_read        = r_ex.mem_read;
  assign bus.ex_mem_write       = r_ex.mem_write;
  assign bus.ex_alu_src         = r_ex.alu_src;
  assign bus.ex_branch          = r_ex.branch;
  assign bus.ex_jump            = r_ex.jump;
  assign bus.ex_jump_reg        = r_ex.jump_reg;
  assign bus.ex_sign_extend_mem = r_ex.sign_ext;
  assign bus.ex_alu_op          = r_ex.alu_op;
  assign bus.ex_mem_size        = r_ex.mem_size;
  assign bus.ex_dest            = r_ex.dest;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Vector table, directed MUL/flush/reset sequences and a
// random run against an instruction-level reference model.
module tb_pipelined_control_unit;
  localparam int L = 4;

  localparam logic [1:0] D_RD  = 2'd0;
  localparam logic [1:0] D_RT  = 2'd1;
  localparam logic [1:0] D_LNK = 2'd2;

  typedef enum int {
    K_ADD, K_JR, K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI,
    K_LW, K_LH, K_LB, K_SW, K_SH, K_SB,
    K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_REGIMM,
    K_J, K_JAL, K_MUL, K_BAD, K_BAD2
  } kind_e;

  // ctl = {valid,rw,m2r,mrd,mwr,asrc,br,j,jr,sx}
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       fixfn;
    logic [9:0] ctl;
    logic [3:0] alu;
    logic [1:0] sz;
    logic [1:0] dsel;
    logic       use_rs;
    logic       use_rt;
  } kinfo_t;

  typedef struct {
    kind_e      k;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       fl;
    logic       e_stall;
    logic       e_valid;
    logic [3:0] e_alu;
    logic [4:0] e_dest;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(
    .REG_ADDR_W(5),
    .ALU_OP_W(4)
  ) bus ();

  pipelined_control_unit #(
    .MUL_LATENCY(L),
    .REG_ADDR_W(5),
    .ALU_OP_W(4),
    .LINK_REG(31)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic kinfo_t kinfo(input kind_e k);
    kinfo_t r;
    r = '0;
    case (k)
      K_ADD:    r = '{6'h00, 6'h20, 1'b1, 10'b1100000000, 4'hF, 2'b00, D_RD, 1'b1, 1'b1};
      K_JR:     r = '{6'h00, 6'h08, 1'b1, 10'b1000000010, 4'h0, 2'b00, D_RD, 1'b1, 1'b0};
      K_ADDI:   r = '{6'h08, 6'h00, 1'b0, 10'b1100010000, 4'h0, 2'b00, D_RT, 1'b1, 1'b0};
      K_ANDI:   r = '{6'h0C, 6'h00, 1'b0, 10'b1100010000, 4'h2, 2'b00, D_RT, 1'b1, 1'b0};
      K_ORI:    r = '{6'h0D, 6'h00, 1'b0, 10'b1100010000, 4'h4, 2'b00, D_RT, 1'b1, 1'b0};
      K_XORI:   r = '{6'h0E, 6'h00, 1'b0, 10'b1100010000, 4'h5, 2'b00, D_RT, 1'b1, 1'b0};
      K_SLTI:   r = '{6'h0A, 6'h00, 1'b0, 10'b1100010000, 4'h6, 2'b00, D_RT, 1'b1, 1'b0};
      K_LW:     r = '{6'h23, 6'h00, 1'b0, 10'b1111010000, 4'h0, 2'b10, D_RT, 1'b1, 1'b0};
      K_LH:     r = '{6'h21, 6'h00, 1'b0, 10'b1111010001, 4'h0, 2'b01, D_RT, 1'b1, 1'b0};
      K_LB:     r = '{6'h20, 6'h00, 1'b0, 10'b1111010001, 4'h0, 2'b00, D_RT, 1'b1, 1'b0};
      K_SW:     r = '{6'h2B, 6'h00, 1'b0, 10'b1000110000, 4'h0, 2'b10, D_RT, 1'b1, 1'b1};
      K_SH:     r = '{6'h29, 6'h00, 1'b0, 10'b1000110000, 4'h0, 2'b01, D_RT, 1'b1, 1'b1};
      K_SB:     r = '{6'h28, 6'h00, 1'b0, 10'b1000110000, 4'h0, 2'b00, D_RT, 1'b1, 1'b1};
      K_BEQ:    r = '{6'h04, 6'h00, 1'b0, 10'b1000001000, 4'h1, 2'b00, D_RT, 1'b1, 1'b1};
      K_BNE:    r = '{6'h05, 6'h00, 1'b0, 10'b1000001000, 4'h1, 2'b00, D_RT, 1'b1, 1'b1};
      K_BLEZ:   r = '{6'h06, 6'h00, 1'b0, 10'b1000001000, 4'h1, 2'b00, D_RT, 1'b1, 1'b0};
      K_BGTZ:   r = '{6'h07, 6'h00, 1'b0, 10'b1000001000, 4'h1, 2'b00, D_RT, 1'b1, 1'b0};
      K_REGIMM: r = '{6'h01, 6'h00, 1'b0, 10'b1000001000, 4'h1, 2'b00, D_RT, 1'b1, 1'b0};
      K_J:      r = '{6'h02, 6'h00, 1'b0, 10'b1000000100, 4'h0, 2'b00, D_RT, 1'b0, 1'b0};
      K_JAL:    r = '{6'h03, 6'h00, 1'b0, 10'b1100000100, 4'h0, 2'b00, D_LNK, 1'b0, 1'b0};
      K_MUL:    r = '{6'h1C, 6'h02, 1'b1, 10'b1100000000, 4'h3, 2'b00, D_RD, 1'b1, 1'b1};
      K_BAD:    r = '{6'h3F, 6'h00, 1'b0, 10'b0, 4'h0, 2'b00, D_RD, 1'b0, 1'b0};
      K_BAD2:   r = '{6'h1C, 6'h00, 1'b1, 10'b0, 4'h0, 2'b00, D_RD, 1'b0, 1'b0};
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [20:0] exp_word(
    input kind_e k, input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd);
    kinfo_t ki;
    logic [4:0] d;
    ki = kinfo(k);
    if (!ki.ctl[9]) return '0;
    case (ki.dsel)
      D_RD:    d = rd;
      D_RT:    d = rt;
      default: d = 5'd31;
    endcase
    return {ki.ctl, ki.alu, ki.sz, d};
  endfunction

  function automatic logic [20:0] dut_word();
    return {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg,
            bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src,
            bus.ex_branch, bus.ex_jump, bus.ex_jump_reg,
            bus.ex_sign_extend_mem, bus.ex_alu_op,
            bus.ex_mem_size, bus.ex_dest};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input kind_e k, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] fn, input logic v,
                       input logic fl);
    kinfo_t ki;
    ki = kinfo(k);
    bus.id_valid  = v;
    bus.id_opcode = ki.op;
    bus.id_funct  = ki.fixfn ? ki.fn : fn;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.id_rd     = rd;
    bus.flush     = fl;
  endtask

  vec_t tbl[18];
  logic [20:0] mulw;
  logic [20:0] m_ex;
  logic        m_load;
  int          m_occ;

  initial begin
    kind_e k;
    kinfo_t ki;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    logic v, fl, lu, e_stall, hold;

    tbl[0]  = '{K_ADD,    5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, 4'hF, 5'd3};
    tbl[1]  = '{K_LW,     5'd9,  5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd8};
    tbl[2]  = '{K_ADD,    5'd8,  5'd11, 5'd10, 1'b0, 1'b1, 1'b0, 4'h0, 5'd0};
    tbl[3]  = '{K_ADD,    5'd8,  5'd11, 5'd10, 1'b0, 1'b0, 1'b1, 4'hF, 5'd10};
    tbl[4]  = '{K_LW,     5'd1,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd0};
    tbl[5]  = '{K_ADD,    5'd0,  5'd11, 5'd10, 1'b0, 1'b0, 1'b1, 4'hF, 5'd10};
    tbl[6]  = '{K_LW,     5'd9,  5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd8};
    tbl[7]  = '{K_J,      5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd8};
    tbl[8]  = '{K_JAL,    5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd31};
    tbl[9]  = '{K_JR,     5'd31, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd0};
    tbl[10] = '{K_LW,     5'd2,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd5};
    tbl[11] = '{K_SW,     5'd3,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 4'h0, 5'd0};
    tbl[12] = '{K_SW,     5'd3,  5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd5};
    tbl[13] = '{K_LB,     5'd4,  5'd6,  5'd0,  1'b0, 1'b0, 1'b1, 4'h0, 5'd6};
    tbl[14] = '{K_BLEZ,   5'd7,  5'd6,  5'd0,  1'b0, 1'b0, 1'b1, 4'h1, 5'd6};
    tbl[15] = '{K_BAD,    5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 4'h0, 5'd0};
    tbl[16] = '{K_ADDI,   5'd1,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 4'h0, 5'd0};
    tbl[17] = '{K_SLTI,   5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b1, 4'h6, 5'd2};

    rst_n = 1'b0;
    drive(K_ADD, 5'd0, 5'd0, 5'd0, 6'h0, 1'b0, 1'b0);
    #1;
    chk("reset word", 32'(dut_word()), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset busy", 32'(bus.mul_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].k, tbl[i].rs, tbl[i].rt, tbl[i].rd,
            6'h15, 1'b1, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d stall", i), 32'(bus.stall),
          32'(tbl[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d valid", i), 32'(bus.ex_valid),
          32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d alu", i), 32'(bus.ex_alu_op),
          32'(tbl[i].e_alu));
      chk($sformatf("tbl%0d dest", i), 32'(bus.ex_dest),
          32'(tbl[i].e_dest));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d word", i), 32'(dut_word()),
            32'(exp_word(tbl[i].k, tbl[i].rs, tbl[i].rt, tbl[i].rd)));
      @(negedge clk);
    end

    // MUL $4,$5,$6 followed by a second MUL
    mulw = exp_word(K_MUL, 5'd5, 5'd6, 5'd4);
    drive(K_MUL, 5'd5, 5'd6, 5'd4, 6'h0, 1'b1, 1'b0);
    #1 chk("mul issue stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    chk("mul alu", 32'(bus.ex_alu_op), 32'h3);
    chk("mul dest", 32'(bus.ex_dest), 32'd4);
    chk("mul busy", 32'(bus.mul_busy), 32'd1);
    @(negedge clk);
    drive(K_MUL, 5'd2, 5'd3, 5'd7, 6'h0, 1'b1, 1'b0);
    for (int c = 1; c <= L; c++) begin
      #1;
      chk($sformatf("mul c%0d stall", c), 32'(bus.stall),
          32'(c < L));
      chk($sformatf("mul c%0d busy", c), 32'(bus.mul_busy),
          32'(c < L));
      chk($sformatf("mul c%0d word", c), 32'(dut_word()),
          32'(mulw));
      @(negedge clk);
    end
    chk("mul2 word", 32'(dut_word()),
        32'(exp_word(K_MUL, 5'd2, 5'd3, 5'd7)));
    chk("mul2 busy", 32'(bus.mul_busy), 32'd1);
    drive(K_ADD, 5'd1, 5'd2, 5'd3, 6'h0, 1'b1, 1'b0);
    #1 chk("mul2 c1 stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    chk("flush stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    chk("flush word", 32'(dut_word()), 32'd0);
    chk("flush busy", 32'(bus.mul_busy), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1 chk("post flush stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 chk("post flush word", 32'(dut_word()),
           32'(exp_word(K_ADD, 5'd1, 5'd2, 5'd3)));
    @(negedge clk);

    // async reset in the middle of a MUL wait
    drive(K_MUL, 5'd5, 5'd6, 5'd4, 6'h0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(K_ADDI, 5'd1, 5'd2, 5'd0, 6'h0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid word", 32'(dut_word()), 32'd0);
    chk("rst mid busy", 32'(bus.mul_busy), 32'd0);
    chk("rst mid stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst exit stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1 chk("rst exit word", 32'(dut_word()),
           32'(exp_word(K_ADDI, 5'd1, 5'd2, 5'd0)));

    m_ex   = exp_word(K_ADDI, 5'd1, 5'd2, 5'd0);
    m_load = 1'b0;
    m_occ  = 0;
    hold   = 1'b0;
    k  = K_ADD;
    rs = '0; rt = '0; rd = '0; fn = '0; v = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!hold) begin
        k  = kind_e'($urandom_range(0, int'(K_BAD2)));
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 31));
        fn = 6'($urandom_range(0, 63));
        v  = ($urandom_range(0, 9) != 0);
      end
      fl = ($urandom_range(0, 15) == 0);
      drive(k, rs, rt, rd, fn, v, fl);
      ki = kinfo(k);
      lu = v && m_load && (m_ex[4:0] != 5'd0) &&
           ((ki.use_rs && rs == m_ex[4:0]) ||
            (ki.use_rt && rt == m_ex[4:0]));
      e_stall = !fl && (m_occ > 0 || lu);
      #1;
      chk($sformatf("rnd%0d stall", n), 32'(bus.stall),
          32'(e_stall));
      chk($sformatf("rnd%0d busy", n), 32'(bus.mul_busy),
          32'(m_occ > 0));
      hold = e_stall;
      if (fl) begin
        m_ex = '0; m_load = 1'b0; m_occ = 0;
      end else if (m_occ > 0) begin
        m_occ--;
      end else if (lu) begin
        m_ex = '0; m_load = 1'b0;
      end else begin
        m_ex   = v ? exp_word(k, rs, rt, rd) : '0;
        m_load = v && ki.ctl[6];
        m_occ  = (v && k == K_MUL) ? L - 1 : 0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d word", n), 32'(dut_word()),
          32'(m_ex));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation MIPS control unit for the 5-stage pipeline. It decodes the instruction in ID with the same opcode/funct map as the single-cycle control unit and registers the control word into the ID/EX boundary. It also owns hazard handling: load-use stall detection, a parametrised multi-cycle MUL occupancy counter, and flush-to-bubble on taken branch/jump. Output feeds the EX stage and drives the IF/ID hold.

Parameters:
MUL_LATENCY, 4, cycles a MUL occupies EX (>=1)
REG_ADDR_W, 5, register index width
ALU_OP_W, 4, ALU operation code width
LINK_REG, 31, destination index written by JAL

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID holds a valid instruction
id_opcode  input  6  instruction[31:26]
id_funct  input  6  instruction[5:0]
id_rs  input  REG_ADDR_W  instruction[25:21]
id_rt  input  REG_ADDR_W  instruction[20:16]
id_rd  input  REG_ADDR_W  instruction[15:11]
flush  input  1  branch/jump resolved taken; kill ID instruction
stall  output  1  combinational; hold PC and IF/ID
mul_busy  output  1  registered; MUL wait in progress
ex_valid  output  1  EX holds a real instruction
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump, ex_jump_reg, ex_sign_extend_mem  output  1 each  registered control
ex_alu_op  output  ALU_OP_W  registered ALU op (1111 = use funct)
ex_mem_size  output  2  00 byte, 01 half, 10 word
ex_dest  output  REG_ADDR_W  resolved write index: rd (R-type, MUL), LINK_REG (JAL), else rt

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs, ex_valid, mul_busy and internal counter go to 0 immediately; stall=0.
- Decode: identical table to single-cycle unit (R-type/jr, ADDI/ANDI/ORI/XORI/SLTI, LW/LH/LB, SW/SH/SB, BEQ/BNE/BGTZ/BLEZ/REGIMM, J/JAL, SPECIAL2 MUL funct 000010). Unknown opcode or id_valid=0 decodes to bubble.
- Bubble: all 1-bit controls 0, ex_alu_op=0, ex_mem_size=00, ex_dest=0, ex_valid=0.
- Source use: rs read by R-type, jr, MUL, I-arith, loads, stores, all branches; rt read by R-type, MUL, stores, BEQ, BNE; J/JAL read neither.
- Load-use hazard: ex_valid & ex_mem_read & ex_dest!=0 & ID instruction reads a matching rs or rt -> stall=1; next edge loads bubble into EX. Exactly one stall cycle per hazard.
- FSM: RUN, MUL_WAIT.
  - RUN: MUL loaded into EX with MUL_LATENCY>1 -> counter=MUL_LATENCY-1, mul_busy=1, go MUL_WAIT.
  - MUL_WAIT: stall=1; EX register holds its value; counter decrements each cycle; on counter reaching 0, mul_busy=0, return RUN, next ID instruction accepted that edge. MUL occupies EX exactly MUL_LATENCY cycles.
  - MUL_LATENCY=1: never enters MUL_WAIT.
- Flush priority: flush=1 forces stall=0, loads bubble into EX next edge, clears counter, returns to RUN (abort MUL), regardless of hazard or MUL_WAIT.
- Load-use and MUL_WAIT simultaneous: MUL_WAIT governs; hazard re-evaluated after exit.
- Back-to-back MULs: second MUL enters EX on exit edge and restarts counter.
- Reset mid-MUL_WAIT: returns to RUN, counter 0, EX bubble.

Test Plan:
- Reset asserted during MUL_WAIT -> same cycle all ex_* = 0, mul_busy=0, stall=0; after release first instruction issues normally.
- LW $8,0($9) then ADD $10,$8,$11 -> stall=1 for 1 cycle, EX bubble (ex_valid=0), then ADD with ex_alu_op=1111, ex_dest=10.
- LW $0 then ADD $10,$0,$11; and LW $8 then J -> stall never asserts.
- MUL $4,$5,$6 with MUL_LATENCY=4 -> ex_alu_op=0011, ex_dest=4 held 4 cycles, stall=1 for 3 cycles, following instruction in EX on cycle 5.
- flush=1 during second MUL_WAIT cycle -> stall drops same cycle, EX bubble next edge, mul_busy=0.
- JAL -> ex_jump=1, ex_reg_write=1, ex_dest=31; JR $31 -> ex_jump_reg=1, ex_reg_write=0.
